// File: rtl/csa_accum_seq.sv
// rtl/csa_accum_seq.sv - sequential carry-save multi-operand accumulator with valid/ready I/O
module csa_accum_seq #(
    parameter int NN = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] num_ops,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NN-1:0] in_a,
    input  logic [NN-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NN-1:0] out_sum,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [NN-1:0] sum_q, sum_d;
    logic [NN-1:0] carry_q, carry_d;
    logic [NN-1:0] out_sum_q, out_sum_d;
    logic [CW-1:0] remaining_q, remaining_d;

    logic [NN-1:0] b_eff;
    logic [NN-1:0] s1, maj1, c1;
    logic [NN-1:0] s2, maj2, c2;
    logic          beat;
    logic [CW-1:0] remaining_dec;

    // 4:2 compression of (sum, carry, a, b_eff) as two cascaded 3:2 stages; carry out of the MSB is dropped
    always_comb begin
        b_eff = (remaining_q == CW'(1)) ? '0 : in_b;
        s1    = sum_q ^ carry_q ^ in_a;
        maj1  = (sum_q & carry_q) | (sum_q & in_a) | (carry_q & in_a);
        c1    = maj1 << 1;
        s2    = s1 ^ c1 ^ b_eff;
        maj2  = (s1 & c1) | (s1 & b_eff) | (c1 & b_eff);
        c2    = maj2 << 1;
    end

    // Controller: next state, next datapath registers
    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        carry_d       = carry_q;
        out_sum_d     = out_sum_q;
        remaining_d   = remaining_q;
        beat          = 1'b0;
        remaining_dec = (remaining_q == CW'(1)) ? '0 : (remaining_q - CW'(2));
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = num_ops;
                    sum_d       = '0;
                    carry_d     = '0;
                    state_d     = (num_ops != '0) ? S_ACCUM : S_RESOLVE;
                end
            end
            S_ACCUM: begin
                beat = in_valid;
                if (beat) begin
                    sum_d       = s2;
                    carry_d     = c2;
                    remaining_d = remaining_dec;
                    if (remaining_dec == '0) begin
                        state_d = S_RESOLVE;
                    end
                end
            end
            S_RESOLVE: begin
                out_sum_d = sum_q + carry_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            out_sum_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_sum_q   <= out_sum_d;
            remaining_q <= remaining_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_csa_accum_seq.sv
// tb/tb_csa_accum_seq.sv - directed and random-sweep bench for csa_accum_seq
module tb_csa_accum_seq;

    localparam int NN = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_ops;
    logic          in_valid;
    logic          in_ready;
    logic [NN-1:0] in_a;
    logic [NN-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [NN-1:0] out_sum;
    logic          busy;

    int checks;
    int errors;

    csa_accum_seq #(.NN(NN), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_job(input logic [CW-1:0] n);
        start   = 1'b1;
        num_ops = n;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Presents a beat and returns at the negedge after it was accepted; ok=0 if never accepted
    task automatic send_beat(input logic [NN-1:0] a, input logic [NN-1:0] b, output bit ok);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        ok       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid at a negedge
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_sum !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b sum=%h expected 0 0 0 0000",
                     in_ready, out_valid, busy, out_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got rdy=%b vld=%b busy=%b expected 000", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        start_job(8'd4);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accum_entry: got rdy=%b busy=%b expected 1 1", in_ready, busy);
        end
        send_beat(16'd1, 16'd2, ok1);
        send_beat(16'd3, 16'd4, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL b2b_accept: got ok=%b%b expected 11", ok1, ok2);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_resolve_cycle: got vld=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd10) begin
            errors++;
            $display("FAIL b2b_result: got vld=%b sum=%0d expected 1 10", out_valid, out_sum);
        end
        accept_result();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_return_idle: got vld=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_odd_count();
        bit ok1, ok2, okv;
        start_job(8'd3);
        send_beat(16'h0100, 16'h0020, ok1);
        send_beat(16'h0003, 16'hFFFF, ok2);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL odd_ready_drop: got rdy=%b expected 0", in_ready);
        end
        wait_valid(okv);
        checks++;
        if (!okv || out_sum !== 16'h0123) begin
            errors++;
            $display("FAIL odd_result: got vld=%b sum=%h expected 1 0123", okv, out_sum);
        end
        accept_result();
    endtask

    task automatic test_wrap();
        bit ok1, okv;
        start_job(8'd2);
        send_beat(16'hFFFF, 16'h0002, ok1);
        wait_valid(okv);
        checks++;
        if (!okv || out_sum !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_result: got vld=%b sum=%h expected 1 0001", okv, out_sum);
        end
        accept_result();
    endtask

    task automatic test_zero_ops();
        start_job(8'd0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_first_cycle: got rdy=%b vld=%b busy=%b expected 0 0 1", in_ready, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'h0000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_result: got vld=%b sum=%h rdy=%b expected 1 0000 0", out_valid, out_sum, in_ready);
        end
        accept_result();
    endtask

    task automatic test_backpressure();
        bit ok1, okv;
        int bad;
        start_job(8'd2);
        send_beat(16'd7, 16'd8, ok1);
        wait_valid(okv);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            start   = (i == 2);
            num_ops = 8'd5;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_sum !== 16'd15 || busy !== 1'b1) bad++;
        end
        start = 1'b0;
        checks++;
        if (!okv || bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d bad cycles (vld=%b sum=%0d busy=%b) expected 0 bad, 1 15 1",
                     bad, out_valid, out_sum, busy);
        end
        start     = 1'b1;
        num_ops   = 8'd4;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_ignored: got busy=%b rdy=%b vld=%b expected 0 0 0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_idle_valid_ignored();
        bit ok1, okv;
        in_valid = 1'b1;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_valid: got rdy=%b busy=%b expected 0 0", in_ready, busy);
        end
        in_valid = 1'b0;
        start_job(8'd2);
        send_beat(16'd9, 16'd1, ok1);
        wait_valid(okv);
        checks++;
        if (!okv || out_sum !== 16'd10) begin
            errors++;
            $display("FAIL idle_valid_no_consume: got vld=%b sum=%0d expected 1 10", okv, out_sum);
        end
        accept_result();
    endtask

    task automatic test_reset_mid_job();
        bit ok1, okv;
        start_job(8'd3);
        send_beat(16'd100, 16'd200, ok1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_sum !== 16'h0000) begin
            errors++;
            $display("FAIL mid_job_reset: got rdy=%b vld=%b busy=%b sum=%h expected 0 0 0 0000",
                     in_ready, out_valid, busy, out_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_job(8'd2);
        send_beat(16'd5, 16'd6, ok1);
        wait_valid(okv);
        checks++;
        if (!okv || out_sum !== 16'd11) begin
            errors++;
            $display("FAIL post_reset_job: got vld=%b sum=%0d expected 1 11", okv, out_sum);
        end
        accept_result();
    endtask

    task automatic test_random_sweep();
        bit ok, okv;
        int bad;
        int rem;
        logic [NN-1:0] a, b, expected;
        logic [CW-1:0] n;
        bad = 0;
        for (int j = 0; j < 200; j++) begin
            n        = CW'($urandom_range(0, 9));
            expected = '0;
            rem      = int'(n);
            start_job(n);
            while (rem > 0) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
                a = NN'($urandom());
                b = NN'($urandom());
                expected = expected + a + ((rem == 1) ? 16'h0000 : b);
                send_beat(a, b, ok);
                if (!ok) bad++;
                rem = (rem == 1) ? 0 : rem - 2;
            end
            wait_valid(okv);
            checks++;
            if (!okv || out_sum !== expected) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL random_job_%0d: n=%0d got vld=%b sum=%h expected 1 %h", j, n, okv, out_sum, expected);
            end
            accept_result();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        num_ops   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_odd_count();
        test_wrap();
        test_zero_ops();
        test_backpressure();
        test_idle_valid_ignored();
        test_reset_mid_job();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
